fifo_wr_ptr_full: RTL
=====================

// Module: fifo_wr_ptr_full
// PURPOSE
//  Write-side pointer and full-flag logic of the dual-clock FIFO, in the write clock domain.
//  Keeps the binary write pointer and drives the Gray-coded pointer into the two-flop synchronizer.
//  That synchronizer carries the pointer into the read domain.
//  Takes the synchronized read Gray pointer back in and generates full, almost_full, fill level and sticky overflow.
//  Also drives the RAM write address and write strobe.
// PARAMETERS
//  ADDR_WIDTH     4  FIFO depth = 2**ADDR_WIDTH; pointers are ADDR_WIDTH+1 bits. Legal range is >= 2.
//  ALMOST_FULL_TH 2  almost_full asserts when free slots <= ALMOST_FULL_TH. Legal range is 1..DEPTH-1.
// PORTS
//  clk          in   1             write-domain clock
//  rst          in   1             synchronous reset, active-low (rst=0 resets on posedge clk)
//  wr_en        in   1             write request from producer
//  rd_gray_sync in   ADDR_WIDTH+1  read Gray pointer, already synchronized into this domain
//  mem_we       out  1             RAM write strobe = wr_en & ~full (combinational)
//  wr_addr      out  ADDR_WIDTH    RAM write address = wbin[ADDR_WIDTH-1:0]
//  wr_gray      out  ADDR_WIDTH+1  registered Gray write pointer; feeds the synchronizer (WIDTH=ADDR_WIDTH+1)
//  full         out  1             registered; FIFO full
//  almost_full  out  1             registered; free slots <= ALMOST_FULL_TH
//  wr_level     out  ADDR_WIDTH+1  registered; conservative fill level, range 0..DEPTH
//  overflow     out  1             sticky; set when wr_en is asserted while full is 1
// BEHAVIOUR
//  Reset (rst=0 at posedge): wbin=0, wr_gray=0, full=0, almost_full=0, wr_level=0, overflow=0.
//    mem_we=0 during reset. Reset mid-operation discards the pointer state; read-side reset is the system's job.
//  Accept: inc = wr_en & ~full.
//    wbin_n = wbin + inc. Wraps modulo 2**(ADDR_WIDTH+1); the MSB is the lap bit.
//    wgray_n = (wbin_n>>1) ^ wbin_n.
//    All of wbin, wr_gray, full, almost_full and wr_level update on the same edge from the _n values.
//    wr_gray is therefore glitch-free: it changes at most 1 bit per cycle.
//  Full: full_n = (wgray_n == {~rd_gray_sync[A:A-1], rd_gray_sync[A-2:0]}), where A = ADDR_WIDTH.
//    full asserts in the same edge as the write that fills the last slot, so there is no overfill window.
//  Level:
//    rbin = gray2bin(rd_gray_sync); wr_level_n = wbin_n - rbin, computed as unsigned (ADDR_WIDTH+1)-bit.
//    almost_full_n = (wr_level_n >= DEPTH-ALMOST_FULL_TH).
//  Pessimism:
//    The read pointer lags by synchronizer latency (2 write clocks), so full and level are pessimistic only.
//    Deassertion of full/almost_full follows rd_gray_sync by 1 clk.
//  Overflow: set when wr_en & full; stays set until reset. The write is dropped and the pointer is unchanged.
//  Simultaneous events:
//    Write accepted and rd_gray_sync advancing in the same cycle: both enter wr_level_n. Level is unchanged net; full recomputed.
//    wr_en held continuously: one write per clk until full.
//  Input assumption: rd_gray_sync changes by at most one Gray step per clk. No checking of this in RTL.
// STRUCTURE
//  Shared package fifo_pkg holds:
//    the default ADDR_WIDTH;
//    functions bin2gray and gray2bin (width-generic via parameter);
//    the full-compare MSB-inversion rule as a function, also used by the read-side empty logic.
//  One sub-module gray_to_bin (combinational XOR-prefix, parameter WIDTH) for rbin. Reused by the read side.
//  All state is in one clocked always block with synchronous active-low reset. No latches.
// TESTING (ADDR_WIDTH=4, DEPTH=16, ALMOST_FULL_TH=2)
//  Reset:
//    Hold rst=0 for 3 clk with wr_en=1 ->
//    wr_addr=0, wr_gray=5'b00000, full=0, almost_full=0, wr_level=0, overflow=0, mem_we=0.
//  Fill:
//    rd_gray_sync=0, 16 writes ->
//    almost_full rises after the 14th write (level 14).
//    full rises after the 16th write, with wr_gray=5'b11000 and wr_level=16.
//  Overflow:
//    Assert wr_en at full ->
//    mem_we=0; wr_addr and wr_gray are unchanged; overflow=1.
//    overflow stays 1 after full clears.
//  Drain:
//    From full, set rd_gray_sync=5'b00001 (rbin=1) ->
//    next edge: full=0, wr_level=15, almost_full=1.
//    Then rd_gray_sync=5'b00011 (rbin=2) -> wr_level=14; almost_full stays 1.
//  Wrap:
//    Reader tracks writer at a constant lag of 4. After 32 writes ->
//    wr_gray back to 5'b00000 and wr_addr wrapped 15->0.
//    Gray Hamming distance is 1 per accepted write; no false full.
//  Reset mid-fill:
//    After 9 writes, pulse rst=0 for 1 clk ->
//    all outputs return to reset values.
//    The next write gives wr_addr=1 and wr_gray=5'b00001.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer helpers for both sides of the dual-clock FIFO
package fifo_pkg;

    localparam int FIFO_ADDR_WIDTH = 4;
    localparam int PTR_MAX         = 32;

    // Pointers of any width up to PTR_MAX are passed zero-extended into ptr_t.
    typedef logic [PTR_MAX-1:0] ptr_t;

    function automatic ptr_t bin2gray(input ptr_t b);
        return (b >> 1) ^ b;
    endfunction

    function automatic ptr_t gray2bin(input ptr_t g);
        ptr_t b;
        b[PTR_MAX-1] = g[PTR_MAX-1];
        for (int i = PTR_MAX - 2; i >= 0; i--)
            b[i] = b[i+1] ^ g[i];
        return b;
    endfunction

    // Gray pointer exactly one lap ahead of g: the two MSBs of an
    // (aw+1)-bit pointer are inverted, the rest is unchanged.
    function automatic ptr_t full_cmp_ptr(input ptr_t g, input int aw);
        return g ^ (ptr_t'(3) << (aw - 1));
    endfunction

endpackage

// File: rtl/gray_to_bin.sv
// gray_to_bin: combinational Gray-to-binary decode as an XOR prefix from the MSB
module gray_to_bin #(
    parameter int WIDTH = 5
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign bin[i] = ^gray[WIDTH-1:i];
    end

endmodule

// File: rtl/fifo_wr_ptr_full.sv
// fifo_wr_ptr_full: write-domain pointer, Gray export and full/level/overflow flags of the dual-clock FIFO
module fifo_wr_ptr_full
    import fifo_pkg::*;
#(
    parameter int ADDR_WIDTH     = FIFO_ADDR_WIDTH,
    parameter int ALMOST_FULL_TH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH:0]   rd_gray_sync,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] wr_addr,
    output logic [ADDR_WIDTH:0]   wr_gray,
    output logic                  full,
    output logic                  almost_full,
    output logic [ADDR_WIDTH:0]   wr_level,
    output logic                  overflow
);

    localparam int PW    = ADDR_WIDTH + 1;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam logic [PW-1:0] AF_LEVEL = PW'(DEPTH - ALMOST_FULL_TH);

    logic [PW-1:0] wbin, wbin_n, wgray_n, rbin, level_n, full_gray;
    logic          inc;

    gray_to_bin #(.WIDTH(PW)) u_rbin (
        .gray (rd_gray_sync),
        .bin  (rbin)
    );

    // Qualifying with rst keeps the RAM strobe quiet while reset is held.
    assign inc       = rst & wr_en & ~full;
    assign mem_we    = inc;
    assign wr_addr   = wbin[ADDR_WIDTH-1:0];
    assign wbin_n    = wbin + PW'(inc);
    assign wgray_n   = PW'(bin2gray(ptr_t'(wbin_n)));
    assign full_gray = PW'(full_cmp_ptr(ptr_t'(rd_gray_sync), ADDR_WIDTH));
    assign level_n   = wbin_n - rbin;

    // Pointer, exported Gray pointer and all flags advance together from the next-state values
    always_ff @(posedge clk) begin
        if (!rst) begin
            wbin        <= '0;
            wr_gray     <= '0;
            full        <= 1'b0;
            almost_full <= 1'b0;
            wr_level    <= '0;
            overflow    <= 1'b0;
        end else begin
            wbin        <= wbin_n;
            wr_gray     <= wgray_n;
            full        <= wgray_n == full_gray;
            almost_full <= level_n >= AF_LEVEL;
            wr_level    <= level_n;
            overflow    <= overflow | (wr_en & full);
        end
    end

endmodule
